tt_ctrl_sel: RTL

Pad-side controller for the design-selection control pads (ctrl_ena, ctrl_sel_inc, ctrl_sel_rst_n; GPIO 38-40). It consumes the per-pad inputs produced by the GPIO pad stage, then synchronises and deglitches them. From these it builds the design-select address, and drives a gated enable for the multiplexer spine inside tt_top. Selection runs entirely on the system clock, with no pad-clocked flops.

---
 rtl/tt_ctrl_sel.sv | 113 +++++++++++
 1 files changed

// File: rtl/tt_ctrl_sel.sv
// tt_ctrl_sel: synchronised, deglitched design-select controller for the ctrl pads
module tt_ctrl_sel #(
   parameter int N_ADDR_BITS   = 10,
   parameter int ADDR_MAX      = 1023,
   parameter int SYNC_STAGES   = 2,
   parameter int FILT_LEN      = 2,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   pad_ctrl_ena,
   input  logic                   pad_ctrl_sel_inc,
   input  logic                   pad_ctrl_sel_rst_n,
   output logic [N_ADDR_BITS-1:0] sel_addr,
   output logic                   sel_ena,
   output logic                   sel_upd,
   output logic                   sel_ovf,
   output logic                   sel_busy
);
   localparam int FW = $clog2(FILT_LEN + 1);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   typedef enum logic [1:0] {CLEAR, SETTLE, RUN} state_t;
   state_t state, state_n;
   logic [2:0] pad;
   logic [2:0] sync [SYNC_STAGES];
   logic [2:0] filt;
   logic [FW-1:0] fcnt [3];
   logic inc_d, inc_rise, clr;
   logic [SW-1:0] settle, settle_n;
   logic [N_ADDR_BITS-1:0] addr_n;
   logic ovf_n, upd_n;
   assign pad = {pad_ctrl_sel_rst_n, pad_ctrl_sel_inc, pad_ctrl_ena};
   assign inc_rise = filt[1] & ~inc_d;
   assign clr = ~filt[2];
   // synchroniser chains, bit 0 ena, bit 1 inc, bit 2 clear_n
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
      end else begin
         sync[0] <= pad;
         for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      end
   end
   // level filters: flip only after FILT_LEN consecutive differing samples
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         filt <= '0;
         for (int i = 0; i < 3; i++) fcnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (sync[SYNC_STAGES-1][i] == filt[i]) fcnt[i] <= '0;
            else if (fcnt[i] == FW'(FILT_LEN - 1)) begin
               filt[i] <= ~filt[i];
               fcnt[i] <= '0;
            end else fcnt[i] <= fcnt[i] + 1'b1;
         end
      end
   end
   // next state and next register values for the select logic
   always_comb begin
      state_n  = state;
      settle_n = settle;
      addr_n   = sel_addr;
      ovf_n    = sel_ovf;
      upd_n    = 1'b0;
      if (state == CLEAR) begin
         addr_n = '0;
         ovf_n  = 1'b0;
         if (!clr) begin
            state_n  = SETTLE;
            settle_n = SW'(SETTLE_CYCLES);
         end
      end else if (clr) begin
         state_n = CLEAR;
         addr_n  = '0;
         ovf_n   = 1'b0;
         upd_n   = |sel_addr;
      end else if (inc_rise && sel_addr != N_ADDR_BITS'(ADDR_MAX)) begin
         addr_n   = sel_addr + 1'b1;
         upd_n    = 1'b1;
         state_n  = SETTLE;
         settle_n = SW'(SETTLE_CYCLES);
      end else begin
         ovf_n = sel_ovf | inc_rise;
         if (state == SETTLE) begin
            settle_n = settle - 1'b1;
            state_n  = (settle <= SW'(1)) ? RUN : SETTLE;
         end
      end
   end
   // state, address and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= CLEAR;
         settle   <= '0;
         inc_d    <= 1'b0;
         sel_addr <= '0;
         sel_ovf  <= 1'b0;
         sel_upd  <= 1'b0;
         sel_ena  <= 1'b0;
         sel_busy <= 1'b1;
      end else begin
         state    <= state_n;
         settle   <= settle_n;
         inc_d    <= filt[1];
         sel_addr <= addr_n;
         sel_ovf  <= ovf_n;
         sel_upd  <= upd_n;
         sel_ena  <= (state_n == RUN) & filt[0];
         sel_busy <= state_n != RUN;
      end
   end
endmodule
